// File: rtl/freqgen_pkg.sv
// freqgen_pkg: shared sizing and clamp helpers for the pulse-rate generator.
// Frequency-counter benches can reuse these helpers to compute expected counts.
//   calc_aw(width, period)    -> accumulator width, wide enough that acc+f never overflows
//   clamp_freq(freq, period)  -> min(freq, period)
package freqgen_pkg;

    function automatic int unsigned calc_aw(input int unsigned width,
                                            input longint unsigned period);
        int unsigned cw;
        cw = $clog2(period + 1);
        return ((width > cw) ? width : cw) + 1;
    endfunction

    function automatic longint unsigned clamp_freq(input longint unsigned freq,
                                                   input longint unsigned period);
        return (freq > period) ? period : freq;
    endfunction

endpackage

// File: rtl/freqgen_if.sv
// freqgen_if: control/status bundle of the pulse-rate generator.
//   en          run enable (master -> slave)
//   freq        requested pulses per window (master -> slave)
//   pulse       generated pulse strobe (slave -> master)
//   ovf         window-end strobe (slave -> master)
//   freq_active clamped rate used in the current window (slave -> master)
//   sat         requested rate exceeded the window length (slave -> master)
interface freqgen_if #(
    parameter int unsigned WIDTH = 16
);
    logic             en;
    logic [WIDTH-1:0] freq;
    logic             pulse;
    logic             ovf;
    logic [WIDTH-1:0] freq_active;
    logic             sat;

    modport master (
        output en, freq,
        input  pulse, ovf, freq_active, sat
    );

    modport slave (
        input  en, freq,
        output pulse, ovf, freq_active, sat
    );
endinterface

// File: rtl/freqgen_gate.sv
// freqgen_gate: gate-window timebase for freqgen.
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en_i         run enable; low clears the window position
//   win_start_o  combinational: this enabled cycle is window cycle 0
//   ovf_o        registered window-end strobe, one cycle wide
module freqgen_gate #(
    parameter int unsigned PERIOD = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic win_start_o,
    output logic ovf_o
);
    localparam int unsigned     GW   = $clog2(PERIOD);
    localparam logic [GW-1:0]   LAST = GW'(PERIOD - 1);

    logic [GW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          last;

    assign last        = (cnt_q == LAST);
    assign win_start_o = en_i && (cnt_q == '0);
    assign ovf_o       = ovf_q;

    always_comb begin
        cnt_d = '0;
        ovf_d = 1'b0;
        if (en_i) begin
            cnt_d = last ? '0 : cnt_q + GW'(1);
            ovf_d = last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: rtl/freqgen.sv
// freqgen: programmable pulse-rate generator. Emits exactly f evenly spread
// single-cycle pulses in every window of PERIOD clk cycles, plus a one-cycle
// ovf strobe coinciding with the pulse decision of the window's last cycle.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    freqgen_if slave: en, freq in; pulse, ovf, freq_active, sat out
module freqgen
    import freqgen_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned PERIOD = 1000
) (
    input  logic      clk,
    input  logic      rst_n,
    freqgen_if.slave  bus
);
    localparam int unsigned   AW    = calc_aw(WIDTH, PERIOD);
    localparam logic [AW-1:0] PER_A = AW'(PERIOD);

    logic             win_start;
    logic             ovf;
    logic [AW-1:0]    acc_q, acc_d;
    logic [AW-1:0]    acc_in;
    logic [AW-1:0]    sum;
    logic             pulse_q, pulse_d;
    logic [WIDTH-1:0] fa_q, fa_d;
    logic             sat_q, sat_d;

    freqgen_gate #(
        .PERIOD (PERIOD)
    ) u_gate (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (bus.en),
        .win_start_o (win_start),
        .ovf_o       (ovf)
    );

    // Bresenham step: fa_d is both the rate used this cycle and the next
    // freq_active, so the window-start sample takes effect immediately.
    always_comb begin
        fa_d    = fa_q;
        sat_d   = sat_q;
        acc_in  = acc_q;
        if (win_start) begin
            fa_d   = WIDTH'(clamp_freq(64'(bus.freq), 64'(PERIOD)));
            sat_d  = 64'(bus.freq) > 64'(PERIOD);
            acc_in = '0;
        end
        sum = acc_in + AW'(fa_d);
        if (sum >= PER_A) begin
            acc_d   = sum - PER_A;
            pulse_d = 1'b1;
        end else begin
            acc_d   = sum;
            pulse_d = 1'b0;
        end
        if (!bus.en) begin
            acc_d   = '0;
            pulse_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            pulse_q <= 1'b0;
            fa_q    <= '0;
            sat_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            pulse_q <= pulse_d;
            fa_q    <= fa_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.pulse       = pulse_q;
    assign bus.ovf         = ovf;
    assign bus.freq_active = fa_q;
    assign bus.sat         = sat_q;
endmodule

// File: tb/tb_freqgen.sv
module tb_freqgen;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    int unsigned total = 0;
    int unsigned bad   = 0;

    freqgen_if #(.WIDTH(16)) bus_a ();
    freqgen_if #(.WIDTH(16)) bus_b ();

    freqgen #(.WIDTH(16), .PERIOD(10)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    freqgen #(.WIDTH(16), .PERIOD(1000)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Sample n output cycles of dut_a; bit i holds output cycle i+1 of the run.
    task automatic win(input int n, output logic [31:0] pm, output logic [31:0] om);
        pm = '0;
        om = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            pm[i] = bus_a.pulse;
            om[i] = bus_a.ovf;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pm, om, pm2, om2;
        int unsigned vals [6] = '{0, 1, 37, 500, 999, 1000};
        int unsigned cnt, novf;
        logic        last_ovf;

        bus_a.en = 1'b0; bus_a.freq = '0;
        bus_b.en = 1'b0; bus_b.freq = '0;
        #1 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_pulse", bus_a.pulse, 0);
        chk("rst_ovf",   bus_a.ovf, 0);
        chk("rst_fa",    bus_a.freq_active, 0);
        chk("rst_sat",   bus_a.sat, 0);

        // freq=4: pulses at output cycles 3,5,8,10, ovf at 10, twice
        bus_a.freq = 16'd4; bus_a.en = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        win(10, pm, om);
        chk("f4_w1_pulse", pm, 32'h294);
        chk("f4_w1_ovf",   om, 32'h200);
        chk("f4_fa",       bus_a.freq_active, 4);
        chk("f4_sat",      bus_a.sat, 0);
        win(10, pm, om);
        chk("f4_w2_pulse", pm, 32'h294);
        chk("f4_w2_ovf",   om, 32'h200);

        bus_a.freq = 16'd0;
        win(10, pm, om);
        chk("f0_pulse", pm, 32'h0);
        chk("f0_ovf",   om, 32'h200);
        chk("f0_fa",    bus_a.freq_active, 0);

        bus_a.freq = 16'd10;
        win(10, pm, om);
        chk("f10_pulse", pm, 32'h3FF);
        chk("f10_ovf",   om, 32'h200);
        chk("f10_sat",   bus_a.sat, 0);

        bus_a.freq = 16'd25;
        win(10, pm, om);
        chk("f25_pulse", pm, 32'h3FF);
        chk("f25_ovf",   om, 32'h200);
        chk("f25_fa",    bus_a.freq_active, 10);
        chk("f25_sat",   bus_a.sat, 1);

        // mid-window change 4 -> 7 at window cycle 5
        bus_a.freq = 16'd4;
        win(5, pm, om);
        bus_a.freq = 16'd7;
        win(5, pm2, om2);
        chk("chg_w1_pulse", pm | (pm2 << 5), 32'h294);
        chk("chg_w1_ovf",   om | (om2 << 5), 32'h200);
        chk("chg_w1_fa",    bus_a.freq_active, 4);
        chk("chg_sat_clr",  bus_a.sat, 0);
        win(1, pm, om);
        chk("chg_fa_upd",   bus_a.freq_active, 7);
        win(9, pm2, om2);
        chk("chg_w2_pulse", pm | (pm2 << 1), 32'h3B6);
        chk("chg_w2_ovf",   om | (om2 << 1), 32'h200);

        // en dropped at window cycle 6 for 3 cycles
        bus_a.freq = 16'd5;
        win(6, pm, om);
        chk("en_part_pulse", pm, 32'h2A);
        chk("en_part_ovf",   om, 32'h0);
        bus_a.en = 1'b0;
        win(3, pm, om);
        chk("en_off_pulse", pm, 32'h0);
        chk("en_off_ovf",   om, 32'h0);
        chk("en_off_fa",    bus_a.freq_active, 5);
        bus_a.en = 1'b1;
        win(10, pm, om);
        chk("en_re_pulse", pm, 32'h2AA);
        chk("en_re_ovf",   om, 32'h200);

        // async reset mid-window while pulse is high
        bus_a.freq = 16'd4;
        win(3, pm, om);
        chk("ar_pre_pulse", pm, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_pulse", bus_a.pulse, 0);
        chk("ar_ovf",   bus_a.ovf, 0);
        chk("ar_fa",    bus_a.freq_active, 0);
        chk("ar_sat",   bus_a.sat, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        win(10, pm, om);
        chk("ar_post_pulse", pm, 32'h294);
        chk("ar_post_ovf",   om, 32'h200);
        chk("ar_post_fa",    bus_a.freq_active, 4);

        // loopback into a pulse counter gated by ovf, PERIOD=1000
        bus_a.en = 1'b0;
        bus_b.en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus_b.freq = 16'(vals[k]);
            cnt = 0;
            novf = 0;
            last_ovf = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                @(posedge clk);
                #1;
                if (bus_b.pulse) cnt++;
                if (bus_b.ovf) novf++;
                if (i == 999) last_ovf = bus_b.ovf;
            end
            chk($sformatf("lb_cnt_%0d", vals[k]), 64'(cnt), 64'(vals[k]));
            chk($sformatf("lb_novf_%0d", vals[k]), 64'(novf), 1);
            chk($sformatf("lb_ovfpos_%0d", vals[k]), last_ovf, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
